spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  Single-clock SPI slave. Shifts WIDTH-bit words in on SDI and out on SDO while CS is low.
//  Sits between the external SPI master and the AES cipher control logic.
//  Delivers each received word on DATA_OUT with a one-cycle done_flag.
//  Transmits the word presented on DATA_IN when data_valid is high.
// PARAMETERS
//  WIDTH  16  word length in bits; counter width is $clog2(WIDTH)
// PORTS
//  CLK         in   1      single clock; system clock and SPI bit clock; all logic on posedge
//  RST_N       in   1      reset, synchronous, active-low
//  CS          in   1      chip select, active-low; high = idle / abort
//  SDI         in   1      serial data from master, sampled on posedge CLK
//  SDO         out  1      serial data to master, registered
//  DATA_IN     in   WIDTH  word to transmit
//  DATA_OUT    out  WIDTH  last completely received word, held until next completion
//  data_valid  in   1      1 = DATA_IN is loaded for the next word; 0 = transmit zeros
//  done_flag   out  1      one-cycle pulse: DATA_OUT has just been updated
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge) clears rx_sr, tx_sr, bit_cnt, DATA_OUT, done_flag and SDO to 0.
//    Reset has priority over everything and aborts any word in progress.
//  - Bit order is MSB first in both directions (default).
//  - Idle (CS=1):
//    - bit_cnt<=0; rx_sr holds its value.
//    - tx_sr <= data_valid ? DATA_IN : 0 on every cycle.
//    - SDO<=0; done_flag<=0.
//  - Active (CS=0), each posedge:
//    - rx_sr <= {rx_sr[WIDTH-2:0],SDI}; bit_cnt<=bit_cnt+1.
//    - SDO <= tx_sr[WIDTH-1]; tx_sr <= tx_sr<<1.
//  - Word end (CS=0 and bit_cnt==WIDTH-1):
//    - DATA_OUT <= {rx_sr[WIDTH-2:0],SDI}; done_flag<=1 for exactly that next cycle.
//    - bit_cnt<=0 (wraps).
//    - tx_sr <= data_valid ? DATA_IN : 0, so back-to-back words need no CS gap.
//  - Latency: done_flag and DATA_OUT become valid 1 cycle after the edge that samples the WIDTH-th bit.
//  - SDO timing: SDO lags tx_sr by one cycle; the master samples SDO bit k on edge k+1.
//  - Any other cycle: done_flag<=0.
//  - CS rising mid-word: partial word discarded; no done_flag; DATA_OUT unchanged; bit_cnt<=0.
//  - data_valid is sampled only on load cycles (idle, or word end); mid-word changes are ignored.
//  - DATA_IN changing mid-word does not affect the word currently being sent.
// CONFIGURATION
//  SPI_LSB_FIRST_EN defined:
//    - rx shifts right: rx_sr <= {SDI,rx_sr[WIDTH-1:1]}.
//    - tx sends tx_sr[0] first and shifts right.
//    - All timing is identical to the default.
//  SPI_LSB_FIRST_EN undefined: MSB first, as described above.
// STRUCTURE
//  - Package spi_pkg:
//    - localparam SPI_WIDTH=16.
//    - localparam SPI_CNT_W=$clog2(SPI_WIDTH).
//    - typedef logic [SPI_WIDTH-1:0] spi_word_t.
//  - No sub-modules: one counter plus two shift registers in a single always block.
// TESTING
//  1. Reset: RST_N=0 for 2 cycles with CS=0 and SDI toggling -> DATA_OUT=0, done_flag=0, SDO=0.
//  2. Receive: CS=0, SDI drives 0xA5C3 MSB first over 16 cycles
//     -> DATA_OUT=0xA5C3, done_flag high exactly 1 cycle.
//  3. Transmit: data_valid=1, DATA_IN=0x1234, CS falls, 17 cycles
//     -> SDO bits read 0x1234 MSB first (lag 1); data_valid=0 -> 0x0000.
//  4. Back-to-back: 8 words 0x0001..0x0008 without CS gap
//     -> 8 done_flag pulses 16 cycles apart; DATA_OUT follows each word.
//  5. Abort: CS=0 for 9 bits, then CS=1, then a full word 0xBEEF
//     -> no pulse on abort; DATA_OUT=0xBEEF afterwards.
//  6. With SPI_LSB_FIRST_EN defined: SDI sends 0x0001 LSB first
//     -> DATA_OUT=0x0001; DATA_IN=0x8000 -> SDO high on its last bit.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   SPI_WIDTH  : default word length in bits
//   SPI_CNT_W  : bit counter width for SPI_WIDTH
//   spi_word_t : one SPI word
package spi_pkg;

  localparam int SPI_WIDTH = 16;
  localparam int SPI_CNT_W = $clog2(SPI_WIDTH);

  typedef logic [SPI_WIDTH-1:0] spi_word_t;

endpackage

// File: rtl/spi_slave.sv
// Single-clock SPI slave between an external SPI master and the AES cipher
// control logic. CLK is both the system clock and the SPI bit clock. While CS
// is low, one bit per posedge is shifted in on SDI and one bit is shifted out
// on SDO.
//
// Ports
//   CLK        : clock; all logic runs on posedge
//   RST_N      : synchronous active-low reset
//   CS         : chip select, active-low; high = idle / abort the current word
//   SDI        : serial data in, sampled on posedge CLK
//   SDO        : serial data out, registered; lags tx_sr by one cycle
//   DATA_IN    : word to transmit
//   DATA_OUT   : last completely received word, held until the next one
//   data_valid : load qualifier for DATA_IN
//   done_flag  : one-cycle pulse when DATA_OUT has just been updated
//
// Load qualifier: data_valid is sampled only on load cycles, which are every
// idle cycle (CS=1) and the word-end cycle. On a load cycle, data_valid=1
// loads DATA_IN into the transmit register and data_valid=0 loads zeros.
// Neither DATA_IN nor data_valid has any effect mid-word. There is no ready
// signal: the slave always accepts the qualifier on a load cycle.
//
// Configuration macro SPI_LSB_FIRST_EN: when defined, both directions are LSB
// first. When undefined (default), both directions are MSB first. Timing is
// identical in both builds.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CS,
  input  logic             SDI,
  output logic             SDO,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  input  logic             data_valid,
  output logic             done_flag
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic [CNT_W-1:0] bit_cnt;

  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic             tx_bit;
  logic [WIDTH-1:0] tx_load;

  // Bit-order dependent shift paths.
`ifdef SPI_LSB_FIRST_EN
  assign rx_next  = {SDI, rx_sr[WIDTH-1:1]};
  assign tx_bit   = tx_sr[0];
  assign tx_shift = tx_sr >> 1;
`else
  assign rx_next  = {rx_sr[WIDTH-2:0], SDI};
  assign tx_bit   = tx_sr[WIDTH-1];
  assign tx_shift = tx_sr << 1;
`endif

  assign tx_load = data_valid ? DATA_IN : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      DATA_OUT  <= '0;
      done_flag <= 1'b0;
      SDO       <= 1'b0;
    end else if (CS) begin
      // Idle or abort: any partial word is dropped and rx_sr keeps its value.
      // The transmit register is reloaded every idle cycle, so the first bit
      // is ready on the edge where CS falls.
      bit_cnt   <= '0;
      tx_sr     <= tx_load;
      SDO       <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      rx_sr <= rx_next;
      SDO   <= tx_bit;
      if (bit_cnt == LAST_BIT) begin
        // Word end. Publish the full word, including the bit sampled on this
        // edge. Reload tx so the next word can follow without a CS gap.
        DATA_OUT  <= rx_next;
        done_flag <= 1'b1;
        bit_cnt   <= '0;
        tx_sr     <= tx_load;
      end else begin
        done_flag <= 1'b0;
        bit_cnt   <= bit_cnt + 1'b1;
        tx_sr     <= tx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave. Bit order follows SPI_LSB_FIRST_EN, so
// the same hand-computed word values apply to both builds.
module tb_spi_slave;

  localparam int W = 16;

  logic         CLK;
  logic         RST_N;
  logic         CS;
  logic         SDI;
  logic         SDO;
  logic [W-1:0] DATA_IN;
  logic [W-1:0] DATA_OUT;
  logic         data_valid;
  logic         done_flag;

  int n_checks  = 0;
  int n_errors  = 0;
  int pulse_cnt = 0;

  logic [W-1:0] tx_word;
  logic [W-1:0] last_out;
  logic         last_sdo;

  spi_slave #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CS         (CS),
    .SDI        (SDI),
    .SDO        (SDO),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .data_valid (data_valid),
    .done_flag  (done_flag)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serial position i (0 = first on the wire) to word bit index.
  function automatic int wire_idx(input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // Drivers. Inputs change on negedge; outputs are sampled on negedge.
  task automatic idle(input int n);
    CS = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Shift nbits of rx_word into the DUT with CS low. SDO is collected into
  // tx_word. done_flag is checked on every bit. At serial position chg_at,
  // DATA_IN and data_valid are changed to exercise the mid-word behaviour.
  task automatic xfer(input logic [W-1:0] rx_word, input int nbits,
                      input int chg_at, input logic [W-1:0] chg_din,
                      input logic chg_dv, output logic [W-1:0] tx_out);
    logic [W-1:0] acc;
    acc = '0;
    CS  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) begin
        DATA_IN    = chg_din;
        data_valid = chg_dv;
      end
      SDI = rx_word[wire_idx(i)];
      @(negedge CLK);
      acc[wire_idx(i)] = SDO;
      last_sdo = SDO;
      check_eq($sformatf("done_flag bit%0d", i), {31'b0, done_flag}, {31'b0, (i == W - 1)});
      if (done_flag) pulse_cnt++;
    end
    tx_out = acc;
  endtask

  // Stimulus
  initial begin
    RST_N      = 1'b0;
    CS         = 1'b0;
    SDI        = 1'b0;
    DATA_IN    = '0;
    data_valid = 1'b0;
    last_sdo   = 1'b0;

    // 1. Reset with CS low and SDI toggling
    repeat (2) begin
      SDI = ~SDI;
      @(negedge CLK);
    end
    check_eq("reset DATA_OUT", 32'(DATA_OUT), 32'h0);
    check_eq("reset done_flag", {31'b0, done_flag}, 32'h0);
    check_eq("reset SDO", {31'b0, SDO}, 32'h0);
    RST_N = 1'b1;
    idle(1);

    // 2. Receive 0xA5C3 with zeros transmitted
    xfer(16'hA5C3, W, -1, '0, 1'b0, tx_word);
    check_eq("rx A5C3", 32'(DATA_OUT), 32'hA5C3);
    check_eq("tx zeros", 32'(tx_word), 32'h0);
    idle(1);
    check_eq("pulse one cycle", {31'b0, done_flag}, 32'h0);
    check_eq("DATA_OUT held", 32'(DATA_OUT), 32'hA5C3);
    check_eq("idle SDO", {31'b0, SDO}, 32'h0);

    // 3. Transmit 0x1234. DATA_IN and data_valid change mid-word; the word in
    //    flight is unaffected and the word-end reload picks up zeros.
    DATA_IN    = 16'h1234;
    data_valid = 1'b1;
    idle(1);
    xfer(16'h0F0F, W, 5, 16'hFFFF, 1'b0, tx_word);
    check_eq("tx 1234", 32'(tx_word), 32'h1234);
    check_eq("rx 0F0F", 32'(DATA_OUT), 32'h0F0F);
    xfer(16'h0000, W, -1, '0, 1'b0, tx_word);
    check_eq("tx after dv=0", 32'(tx_word), 32'h0);

    // 4. Eight words back to back with no CS gap
    idle(1);
    pulse_cnt = 0;
    for (int w = 1; w <= 8; w++) begin
      xfer(W'(w), W, -1, '0, 1'b0, tx_word);
      check_eq($sformatf("b2b word %0d", w), 32'(DATA_OUT), w);
    end
    check_eq("b2b pulse count", pulse_cnt, 8);

    // 5. Abort after 9 bits, then a full 0xBEEF
    idle(1);
    last_out = DATA_OUT;
    xfer(16'hBEEF, 9, -1, '0, 1'b0, tx_word);
    idle(1);
    check_eq("abort no pulse", {31'b0, done_flag}, 32'h0);
    check_eq("abort DATA_OUT kept", 32'(DATA_OUT), 32'(last_out));
    xfer(16'hBEEF, W, -1, '0, 1'b0, tx_word);
    check_eq("rx BEEF", 32'(DATA_OUT), 32'hBEEF);

    // 6. Receive 0x0001 and transmit 0x8000
    idle(1);
    DATA_IN    = 16'h8000;
    data_valid = 1'b1;
    idle(1);
    xfer(16'h0001, W, -1, '0, 1'b1, tx_word);
    check_eq("rx 0001", 32'(DATA_OUT), 32'h0001);
    check_eq("tx 8000", 32'(tx_word), 32'h8000);
`ifdef SPI_LSB_FIRST_EN
    check_eq("lsb SDO last bit", {31'b0, last_sdo}, 32'h1);
`else
    check_eq("msb SDO last bit", {31'b0, last_sdo}, 32'h0);
`endif

    // Reset mid-word clears DATA_OUT and aborts the word
    data_valid = 1'b0;
    xfer(16'h5555, 4, -1, '0, 1'b0, tx_word);
    RST_N = 1'b0;
    @(negedge CLK);
    check_eq("mid reset DATA_OUT", 32'(DATA_OUT), 32'h0);
    check_eq("mid reset SDO", {31'b0, SDO}, 32'h0);
    RST_N = 1'b1;
    idle(1);
    xfer(16'h3C96, W, -1, '0, 1'b0, tx_word);
    check_eq("rx after reset", 32'(DATA_OUT), 32'h3C96);

    // Report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
